fifo_enq_arbiter: RTL and testbench

Round-robin arbiter that shares the single enqueue port of one `fifo` instance (DATA_WIDTH=8, ADDR_WIDTH=4 default) between NUM_REQ producers. It sits directly in front of the FIFO:
- It watches `full`.
- It selects at most one requester per cycle and drives `enq`/`data_in` with zero added latency.
- It keeps a fairness pointer, an optional burst lock and a beat counter.

---
 rtl/fifo_enq_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fifo_enq_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_enq_arbiter
//
// Round-robin arbiter that shares the single enqueue port of one FIFO between
// NUM_REQ producers. The grant is combinational, so a beat reaches the FIFO in
// the same cycle its requester presents it.
//
// Optional feature macro: FIFO_ARB_BURST_EN
//   undefined : strict per-beat round-robin.
//   defined   : a winner keeps the port for up to MAX_BURST consecutive beats.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   reset        : synchronous, active-high
//   req_valid    : [NUM_REQ]   requester i holds a beat
//   req_data     : [NUM_REQ*DATA_WIDTH] requester i's beat at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : [NUM_REQ]   one-hot or zero grant, combinational
//   fifo_full    : FIFO full flag (valid combinationally for the current cycle)
//   fifo_enq     : FIFO enqueue strobe, combinational
//   fifo_data_in : [DATA_WIDTH] granted beat, zero when nothing is granted
//   last_id      : [ID_WIDTH]  registered id of the last accepted requester
//   beat_cnt     : [CNT_WIDTH] registered count of accepted beats, wraps
// -----------------------------------------------------------------------------
module fifo_enq_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_enq,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_WIDTH-1:0]           last_id,
  output logic [CNT_WIDTH-1:0]          beat_cnt
);

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  sel_found;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  grant_vld;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_en;
  logic [ID_WIDTH-1:0]   grant_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = grant_en && (grant_id == ID_WIDTH'(gi));
    end
  endgenerate

  // Unlocked selection: first valid requester scanning upward from ptr.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && req_valid[ID_WIDTH'(idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [7:0]          burst_q, burst_d;
  logic                lock_hold;

  // The lock holds only while the owner still has data and budget; otherwise
  // it releases in the same cycle and the unlocked scan runs from ptr, which
  // already equals owner+1 because the lock was taken on an unlocked grant.
  assign lock_hold = (state_q == S_OWN) && req_valid[owner_q] && (burst_q < MAX_BURST_B);
  assign grant_vld = lock_hold || sel_found;
  assign grant_id  = lock_hold ? owner_q : sel_id;
`else
  assign grant_vld = sel_found;
  assign grant_id  = sel_id;
`endif

  assign grant_en     = grant_vld && !fifo_full && !reset;
  assign grant_nxt    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign fifo_enq     = grant_en;
  assign fifo_data_in = grant_en ? data_arr[grant_id] : '0;
  assign last_id      = last_id_q;
  assign beat_cnt     = beat_cnt_q;

  always_comb begin
    ptr_d      = ptr_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
`ifdef FIFO_ARB_BURST_EN
    state_d    = state_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
`endif
    if (grant_en) begin
      last_id_d  = grant_id;
      beat_cnt_d = beat_cnt_q + 1'b1;
`ifdef FIFO_ARB_BURST_EN
      if (lock_hold) begin
        burst_d = burst_q + 8'd1;
      end else begin
        ptr_d   = grant_nxt;
        state_d = S_OWN;
        owner_d = grant_id;
        burst_d = 8'd1;
      end
`else
      ptr_d = grant_nxt;
`endif
    end
`ifdef FIFO_ARB_BURST_EN
    // Nobody valid and the FIFO not stalling: drop the lock. A full stall keeps it.
    else if (!fifo_full && !grant_vld) begin
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      last_id_q  <= '0;
      beat_cnt_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      state_q    <= S_IDLE;
      owner_q    <= '0;
      burst_q    <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef FIFO_ARB_BURST_EN
      state_q    <= state_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_enq_arbiter
//
// Random-stimulus bench for fifo_enq_arbiter. A reference model of the
// arbitration rules predicts each cycle's grant; predictions go into a queue
// and a monitor on the falling edge pops and compares them with the DUT.
// A second instance with CNT_WIDTH=4 shares the inputs to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_fifo_enq_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic              fifo_full;

  logic [N-1:0]      req_ready,  req_ready4;
  logic              fifo_enq,   fifo_enq4;
  logic [DW-1:0]     fifo_din,   fifo_din4;
  logic [1:0]        last_id,    last_id4;
  logic [15:0]       beat_cnt;
  logic [3:0]        beat_cnt4;

  always #5 clk = ~clk;

  fifo_enq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_enq(fifo_enq),
    .fifo_data_in(fifo_din), .last_id(last_id), .beat_cnt(beat_cnt)
  );

  fifo_enq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(4)) u_dut_c4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready4), .fifo_full(fifo_full), .fifo_enq(fifo_enq4),
    .fifo_data_in(fifo_din4), .last_id(last_id4), .beat_cnt(beat_cnt4)
  );

  typedef struct {
    logic [N-1:0]  ready;
    logic          enq;
    logic [DW-1:0] data;
    int            last;
    int            cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_beats  = 0;

  // Reference model state
  int      m_ptr, m_last, m_cnt, m_owner, m_burst;
  bit      m_locked;
  bit      rv [N];
  logic [DW-1:0] rd [N];
  logic [DW-1:0] fq[$];

  // Phase table: cycles, reset, new-request mask, raise %, dequeue %
  localparam int NPH = 14;
  int ph_cyc  [NPH] = '{2,  24, 24, 6,  12, 30, 1,  4,  1,  4,  300, 1,  200, 100};
  int ph_rst  [NPH] = '{1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   1,  0,   0};
  int ph_mask [NPH] = '{15, 15, 4,  3,  3,  0,  8,  0,  1,  0,  15,  15, 15,  3};
  int ph_newp [NPH] = '{100,100,100,100,100,0,  100,0,  100,0,  40,  100,70,  100};
  int ph_deqp [NPH] = '{100,100,0,  0,  25, 100,100,100,100,100,60,  60, 90,  100};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Returns the requester the rules select this cycle, or -1; cont marks a
  // beat that continues an existing burst.
  function automatic int pick(output bit cont);
    int start;
    cont = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    if (m_locked && rv[m_owner] && m_burst < MB) begin
      cont = 1'b1;
      return m_owner;
    end
    start = m_locked ? (m_owner + 1) % N : m_ptr;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++)
      if (rv[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_ready",    32'(req_ready),    32'(e.ready));
        check("fifo_enq",     32'(fifo_enq),     32'(e.enq));
        check("fifo_data_in", 32'(fifo_din),     32'(e.data));
        check("last_id",      32'(last_id),      32'(e.last));
        check("beat_cnt",     32'(beat_cnt),     32'(e.cnt % 65536));
        check("beat_cnt_w4",  32'(beat_cnt4),    32'(e.cnt % 16));
        check("req_ready_w4", 32'(req_ready4),   32'(e.ready));
        if (e.enq) begin
          n_beats++;
          $display("beat %0d: ready=%b data=%02h last_id=%0d beat_cnt=%0d",
                   n_beats, req_ready, fifo_din, last_id, beat_cnt);
        end
      end
    end
  end

  // Stimulus + model
  initial begin
    int   sel;
    bit   cont, acc, full;
    exp_t e;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; rd[i] = '0; end
    @(posedge clk); #1;
    m_ptr = 0; m_last = 0; m_cnt = 0; m_owner = 0; m_burst = 0; m_locked = 1'b0;

    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < ph_cyc[p]; c++) begin
        for (int i = 0; i < N; i++)
          if (!rv[i] && ph_mask[p][i] && $urandom_range(99) < ph_newp[p]) begin
            rv[i] = 1'b1;
            rd[i] = 8'($urandom);
          end
        full  = (fq.size() >= DEPTH);
        reset = ph_rst[p][0];
        fifo_full = full;
        for (int i = 0; i < N; i++) begin
          req_valid[i]          = rv[i];
          req_data[i*DW +: DW]  = rd[i];
        end

        sel = pick(cont);
        acc = !ph_rst[p][0] && !full && (sel >= 0);
        e.ready = '0;
        if (acc) e.ready[sel] = 1'b1;
        e.enq  = acc;
        e.data = acc ? rd[sel] : '0;
        e.last = m_last;
        e.cnt  = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        if (ph_rst[p][0]) begin
          m_ptr = 0; m_last = 0; m_cnt = 0; m_owner = 0; m_burst = 0; m_locked = 1'b0;
        end else if (acc) begin
          m_cnt++;
          m_last = sel;
          fq.push_back(rd[sel]);
          rv[sel] = 1'b0;
          if (cont) begin
            m_burst++;
          end else begin
            m_ptr = (sel + 1) % N;
            m_locked = 1'b1;
            m_owner = sel;
            m_burst = 1;
          end
        end else if (!full && sel < 0) begin
          m_locked = 1'b0;
        end
        if (fq.size() > 0 && $urandom_range(99) < ph_deqp[p]) void'(fq.pop_front());
        #1;
      end
    end

    reset = 1'b0;
    req_valid = '0;
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
